// File: rtl/vram_pkg.sv
// Shared constants for the CPU-side VRAM sequencer: register selects, remap modes, steps, prefetch states.
package vram_pkg;

   localparam logic [2:0] SEL_VMAIN   = 3'd0;
   localparam logic [2:0] SEL_VMADDL  = 3'd1;
   localparam logic [2:0] SEL_VMADDH  = 3'd2;
   localparam logic [2:0] SEL_VMDATAL = 3'd3;
   localparam logic [2:0] SEL_VMDATAH = 3'd4;
   localparam logic [2:0] SEL_RDL     = 3'd5;
   localparam logic [2:0] SEL_RDH     = 3'd6;

   localparam logic [1:0] REMAP_NONE  = 2'd0;
   localparam logic [1:0] REMAP_8BIT  = 2'd1;
   localparam logic [1:0] REMAP_9BIT  = 2'd2;
   localparam logic [1:0] REMAP_10BIT = 2'd3;

   localparam logic [14:0] STEP_1   = 15'd1;
   localparam logic [14:0] STEP_32  = 15'd32;
   localparam logic [14:0] STEP_128 = 15'd128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PF_RD  = 2'd1,
      PF_CAP = 2'd2
   } pf_state_t;

   function automatic logic [14:0] incr_step(input logic [1:0] inc_sel);
      case (inc_sel)
         2'b00:   return STEP_1;
         2'b01:   return STEP_32;
         default: return STEP_128;
      endcase
   endfunction

endpackage

// File: rtl/vram_addr_remap.sv
// Combinational VRAM word-address bit rotation used for 2/4/8bpp tile-friendly CPU access.
// Zero latency; no flow control.
module vram_addr_remap
   import vram_pkg::*;
#(
   parameter int AW = 15
) (
   input  logic [1:0]    mode,
   input  logic [AW-1:0] addr,
   output logic [AW-1:0] remapped
);

   always_comb begin
      remapped = addr;
      case (mode)
         REMAP_8BIT:  remapped = {addr[AW-1:8],  addr[4:0], addr[7:5]};
         REMAP_9BIT:  remapped = {addr[AW-1:9],  addr[5:0], addr[8:6]};
         REMAP_10BIT: remapped = {addr[AW-1:10], addr[6:0], addr[9:7]};
         default:     remapped = addr;
      endcase
   end

endmodule

// File: rtl/vram_ctrl.sv
// CPU VRAM sequencer: VMAIN/VMADD/VMDATA writes, VMDATAREAD prefetch, PPU-priority port arbitration.
// Bank strobes one cycle after the register access; PPU defers prefetches; VRAM_WRITE_GUARD_EN drops CPU writes during PPU.
module vram_ctrl
   import vram_pkg::*;
#(
   parameter int AW = 15,
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [2:0]      reg_sel,
   input  logic            reg_wr,
   input  logic            reg_rd,
   input  logic [7:0]      reg_din,
   output logic [7:0]      reg_dout,
   input  logic            ppu_active,
   input  logic [AW-1:0]   ppu_addr,
   output logic [2*DW-1:0] ppu_rdata,
   output logic [AW-1:0]   addra,
   output logic [AW-1:0]   addrb,
   output logic            rda,
   output logic            rdb,
   output logic            wra,
   output logic            wrb,
   output logic [DW-1:0]   dina,
   output logic [DW-1:0]   dinb,
   input  logic [DW-1:0]   douta,
   input  logic [DW-1:0]   doutb
);

   logic [1:0]      inc_sel;
   logic [1:0]      remap_mode;
   logic            inc_hi;
   logic [AW-1:0]   vmadd, vmadd_nxt;
   logic [AW-1:0]   pf_addr, pf_addr_nxt;
   logic [AW-1:0]   wr_addr, wr_addr_remap, pf_addr_remap;
   logic [DW-1:0]   wr_dat;
   logic            wr_vld, wr_hi, wr_go;
   logic [2*DW-1:0] rbuf;
   pf_state_t       state, state_nxt;
   logic            pf_pend, pf_pend_nxt;
   logic            addr_wr, data_wr, data_inc, rd_inc, pf_set;

   vram_addr_remap #(.AW(AW)) u_remap_wr (
      .mode     (remap_mode),
      .addr     (vmadd),
      .remapped (wr_addr_remap)
   );

   vram_addr_remap #(.AW(AW)) u_remap_pf (
      .mode     (remap_mode),
      .addr     (pf_addr),
      .remapped (pf_addr_remap)
   );

   assign addr_wr  = reg_wr && (reg_sel == SEL_VMADDL || reg_sel == SEL_VMADDH);
   assign data_wr  = reg_wr && (reg_sel == SEL_VMDATAL || reg_sel == SEL_VMDATAH);
   assign data_inc = data_wr && ((reg_sel == SEL_VMDATAH) == inc_hi);
   assign rd_inc   = reg_rd && ((reg_sel == SEL_RDL && !inc_hi) || (reg_sel == SEL_RDH && inc_hi));
   assign pf_set   = addr_wr || rd_inc;
   assign ppu_rdata = {doutb, douta};

`ifdef VRAM_WRITE_GUARD_EN
   assign wr_go = wr_vld && !ppu_active;
`else
   assign wr_go = wr_vld;
`endif

   // Address updates; a read-triggered prefetch targets the address before the increment.
   always_comb begin
      vmadd_nxt   = vmadd;
      pf_addr_nxt = pf_addr;
      if (reg_wr && reg_sel == SEL_VMADDL)
         vmadd_nxt = {vmadd[AW-1:8], reg_din};
      else if (reg_wr && reg_sel == SEL_VMADDH)
         vmadd_nxt = {reg_din[AW-9:0], vmadd[7:0]};
      else if (data_inc || rd_inc)
         vmadd_nxt = vmadd + AW'(incr_step(inc_sel));
      if (addr_wr)
         pf_addr_nxt = vmadd_nxt;
      else if (rd_inc)
         pf_addr_nxt = vmadd;
   end

   // Port arbitration (CPU write > PPU fetch > prefetch) and prefetch sequencing.
   always_comb begin
      state_nxt   = state;
      pf_pend_nxt = pf_pend || pf_set;
      addra       = pf_addr_remap;
      addrb       = pf_addr_remap;
      rda         = 1'b0;
      rdb         = 1'b0;
      wra         = 1'b0;
      wrb         = 1'b0;
      dina        = wr_dat;
      dinb        = wr_dat;
      if (wr_go) begin
         addra = wr_addr;
         addrb = wr_addr;
         wra   = !wr_hi;
         wrb   = wr_hi;
      end else if (ppu_active) begin
         addra = ppu_addr;
         addrb = ppu_addr;
         rda   = 1'b1;
         rdb   = 1'b1;
      end else if (state == PF_RD) begin
         rda = 1'b1;
         rdb = 1'b1;
      end
      case (state)
         IDLE: begin
            if (pf_pend && !ppu_active) begin
               state_nxt   = PF_RD;
               pf_pend_nxt = pf_set;
            end
         end
         PF_RD: begin
            if (!wr_go && !ppu_active) begin
               state_nxt = PF_CAP;
            end else begin
               state_nxt   = IDLE;
               pf_pend_nxt = 1'b1;
            end
         end
         PF_CAP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         pf_pend    <= 1'b0;
         inc_sel    <= 2'b00;
         remap_mode <= REMAP_NONE;
         inc_hi     <= 1'b0;
         vmadd      <= '0;
         pf_addr    <= '0;
         wr_vld     <= 1'b0;
         wr_hi      <= 1'b0;
         wr_addr    <= '0;
         wr_dat     <= '0;
         rbuf       <= '0;
         reg_dout   <= '0;
      end else begin
         state   <= state_nxt;
         pf_pend <= pf_pend_nxt;
         vmadd   <= vmadd_nxt;
         pf_addr <= pf_addr_nxt;
         wr_vld  <= data_wr;
         if (reg_wr && reg_sel == SEL_VMAIN) begin
            inc_sel    <= reg_din[1:0];
            remap_mode <= reg_din[3:2];
            inc_hi     <= reg_din[7];
         end
         if (data_wr) begin
            wr_hi   <= (reg_sel == SEL_VMDATAH);
            wr_addr <= wr_addr_remap;
            wr_dat  <= reg_din;
         end
         if (reg_rd && reg_sel == SEL_RDL)
            reg_dout <= rbuf[DW-1:0];
         else if (reg_rd && reg_sel == SEL_RDH)
            reg_dout <= rbuf[2*DW-1:DW];
         if (state == PF_CAP)
            rbuf <= {doutb, douta};
      end
   end

endmodule

// File: doc/vram_ctrl.md
Name: vram_ctrl

Overview:
- CPU-side sequencer and arbiter for the dual 8-bit SNES VRAM (low bank A, high bank B, 32K x 8 each, 1-cycle registered read, writes suppress read).
- Implements VMAIN/VMADD/VMDATA write path and the VMDATAREAD prefetch buffer.
- Address remapping and auto-increment are applied here.
- Arbitrates the two VRAM ports between PPU fetches (priority) and CPU accesses.

Parameters:
- AW, 15, VRAM word address width.
- DW, 8, per-bank data width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- reg_sel  in  3  0=$2115 VMAIN, 1=$2116 VMADDL, 2=$2117 VMADDH, 3=$2118 VMDATAL, 4=$2119 VMDATAH, 5=$2139 RDL, 6=$213A RDH
- reg_wr  in  1  one-cycle register write strobe
- reg_rd  in  1  one-cycle register read strobe
- reg_din  in  8  write data
- reg_dout  out  8  read data, valid cycle after reg_rd
- ppu_active  in  1  PPU rendering and not forced blank; PPU owns ports
- ppu_addr  in  15  PPU fetch word address
- ppu_rdata  out  16  {doutb,douta} pass-through
- addra, addrb  out  15  bank addresses
- rda, rdb, wra, wrb  out  1  bank strobes
- dina, dinb  out  8  bank write data
- douta, doutb  in  8  bank read data

Behaviour:
- Reset values:
  - vmain=0 (step 1, increment after low byte, no remap); vmadd=0; rbuf=0.
  - reg_dout=0; all wr/rd strobes 0; addra=addrb=0; dina=dinb=0.
  - FSM=IDLE, pf_pend=0.
- Reset asserted mid-operation aborts any pending write or prefetch; no strobe is issued afterwards.
- Increment step = vmain[1:0]: 00→1, 01→32, 1x→128. Added modulo 2^15; 0x7FFF+1 wraps to 0x0000.
- Remap on vmain[3:2], applied to every CPU VRAM address; vmadd itself is stored unremapped:
  - 00: none.
  - 01: a[14:8],a[4:0],a[7:5].
  - 10: a[14:9],a[5:0],a[8:6].
  - 11: a[14:10],a[6:0],a[9:7].
- VMADDL/H write (cycle N):
  - vmadd byte updated at N+1.
  - pf_pend set; prefetch reads the new address.
- VMDATAL/H write (cycle N):
  - At N+1, if port free: wra (L) or wrb (H) pulses one cycle at remap(vmadd), data=reg_din.
  - vmadd increments at N+1 when the byte matches vmain[7] (0→L, 1→H).
  - No prefetch is triggered.
- RDL/RDH read (cycle N):
  - reg_dout=rbuf[7:0] or rbuf[15:8] at N+1.
  - If the byte matches vmain[7], vmadd increments at N+1 and pf_pend is set; the prefetch uses the pre-increment address.
- Prefetch FSM: IDLE→PF_RD (rda=rdb=1 at remap(vmadd))→PF_CAP (rbuf←{doutb,douta})→IDLE.
  - Entered from IDLE when pf_pend=1 and port free; pf_pend clears on entering PF_RD.
  - New pf_pend set in PF_RD/PF_CAP re-runs the prefetch afterwards.
- Port free = !ppu_active.
  - While ppu_active: addra=addrb=ppu_addr, rda=rdb=1, and ppu_rdata is valid next cycle.
  - Prefetch stays pending (deferred, not dropped).
- Simultaneous CPU data write and prefetch in PF_RD: write wins that cycle; prefetch retries (FSM back to IDLE, pf_pend=1).
- Back-to-back register accesses every cycle must be supported.

Optional Feature:
- VRAM_WRITE_GUARD_EN
  - Defined: CPU data writes while ppu_active are dropped; vmadd still increments.
  - Undefined: the write steals that cycle's port (wra/wrb at CPU address, PPU read suppressed), and ppu_rdata is stale the following cycle.

Decomposition:
- Package vram_pkg holds:
  - reg_sel index constants;
  - remap mode encodings;
  - increment step constants (1/32/128);
  - prefetch FSM state enum.
- Sub-module vram_addr_remap: combinational 15-bit translation from mode plus address.

Test Plan:
- Reset, then write VMAIN=0x80, VMADD=0x1234, VMDATAL=0xAA, VMDATAH=0x55 → wra at 0x1234/0xAA; wrb at 0x1234/0x55; vmadd=0x1235 after the H write only.
- VMAIN=0x01, VMADD=0x7FF0, four VMDATAL writes (incr low) → addresses 0x7FF0, 0x0010, 0x0030, 0x0050 (wrap).
- VMAIN=0x04 (mode 01), VMADD=0x00E3, write → addra=0x001F.
- Preload [0x0100]={0xBE,0xEF}; VMAIN=0x00, VMADD=0x0100; read RDL → first read returns 0xEF; prefetch targets 0x0100; vmadd=0x0101.
- ppu_active=1 during VMADD write → no rda until ppu_active=0, then one prefetch; with VRAM_WRITE_GUARD_EN a VMDATAL write in this window produces no wra but vmadd+1.
- Assert resetn low while in PF_RD → all strobes 0 immediately, rbuf=0, FSM=IDLE.
